i2c_target: RTL and testbench
=============================

# i2c_target

Responder-side I2C engine: a 7-bit-addressed target that watches the bus for START/STOP, matches its address, ACKs, and moves data bytes between the bus and a simple byte-wide user interface. It sits beside the bus-master controller on the same open-drain SCL/SDA pair. It is the receiving end for master writes and the data source for master reads. No clock stretching; standard/fast mode with clk at least 16× SCL.

## Interface
- TARGET_ADDR, 7'h50, 7-bit address the block responds to
- SYNC_STAGES, 2, synchronizer depth for scl_in/sda_in (≥2)
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- scl_in  in  1  raw SCL from pad (asynchronous)
- sda_in  in  1  raw SDA from pad (asynchronous)
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release
- rx_data  out  8  last byte written by master
- rx_valid  out  1  one-clk pulse; rx_data valid
- tx_data  in  8  byte to return on a master read; sampled when tx_req=1
- tx_req  out  1  one-clk pulse; tx_data loaded on this edge
- busy  out  1  1 from address match until STOP/NACK/restart
- rw_o  out  1  R/W bit of current transaction (1 = read)

## Operation
- Inputs pass SYNC_STAGES flops. Edges are taken on synchronized signals: scl_rise, scl_fall.
- START (incl. repeated): SDA falls while SCL high. STOP: SDA rises while SCL high. Both dominate all other events in that cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START from any state → ADDR. Bit counter cleared, sda_oe=0.
- STOP from any state → IDLE. sda_oe=0, busy=0.
- ADDR: shift SDA MSB-first on 8 scl_rise. After the 8th bit:
  - Upper 7 bits == TARGET_ADDR → ADDR_ACK. Latch rw_o, set busy.
  - Mismatch → IDLE; the rest of the transaction is ignored.
- ADDR_ACK: sda_oe=1 from the scl_fall after the 8th bit to the scl_fall after the 9th bit.
  - rw=0 → WR_DATA.
  - rw=1 → tx_req pulses at the first of those two scl_falls, and shift register loads tx_data.
- WR_DATA: 8 bits on scl_rise. At the 8th bit, rx_data updates and rx_valid pulses in the same clk. Then → WR_ACK.
- WR_ACK: ACK driven the same way as ADDR_ACK, then → WR_DATA. The block always ACKs; there is no receive backpressure.
- RD_DATA: on each scl_fall, drive sda_oe = ~shift[7] and shift left.
  - The first bit is driven at the scl_fall that ends the ACK.
  - After the 8th scl_fall the block releases SDA → RD_ACK.
- RD_ACK: sample SDA on the 9th scl_rise.
  - 0 (ACK) → tx_req pulse and load, then RD_DATA.
  - 1 (NACK) → IDLE with busy=0, SDA released; STOP or restart expected.
- Bit counter is 4 bits, 0..8. It saturates, never wraps.

## Timing
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, rw_o=0, state IDLE, counters 0.
- Synchronizer latency SYNC_STAGES+1 clk from pad to edge detect. All bus responses are relative to the synchronized edges.
- sda_oe changes only 1 clk after a synchronized scl_fall, or on START/STOP/reset. It never changes while synchronized SCL is high.
- rx_valid: 1 clk after the scl_rise of the 8th data bit.
- tx_req: 1 clk after the qualifying scl_fall (ADDR_ACK) or scl_rise (RD_ACK). tx_data must be valid in that same cycle.
- Reset mid-transfer releases SDA immediately (asynchronous). The block re-arms at the next START.

## Structure
- Package i2c_pkg holds:
  - target state encoding
  - ACK=1'b0 and NACK=1'b1 constants
  - the 7-bit address width constant
- Sub-module i2c_bus_sync: synchronizers, scl_rise/scl_fall, start_det/stop_det. It is shared with any future bus monitor.
- FSM, bit counter, and shift register sit in i2c_target.

## Test plan
- Write to 0x50 with bytes 0xA5 and 0x3C, then STOP → ACK on address and both bytes. rx_valid pulses twice with 0xA5, then 0x3C. busy clears after STOP.
- Write to 0x51 → no ACK (SDA stays high on the 9th clock). No rx_valid, busy=0.
- Read from 0x50 with tx_data 0x96 then 0x0F; master ACKs then NACKs → bus shows 0x96, 0x0F MSB-first. Two tx_req pulses; after the NACK, SDA is released and the state is IDLE.
- Write 1 byte, then repeated START and read from 0x50 → rx_valid for the write byte. rw_o goes 0→1 and the read returns tx_data.
- STOP injected mid-byte (after 4 bits of a write) → state IDLE, no rx_valid, sda_oe=0.
- rst_n asserted while the block is driving ACK → sda_oe=0 asynchronously. The next transaction after reset completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
//------------------------------------------------------------------
// i2c_pkg - shared types and constants for the I2C target. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

    localparam int ADDR_W = 7;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [3:0] BIT_CNT_MAX = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_DATA  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    // Bit counter increment that sticks at BIT_CNT_MAX instead of wrapping.
    function automatic logic [3:0] cnt_inc(input logic [3:0] cnt);
        return (cnt >= BIT_CNT_MAX) ? BIT_CNT_MAX : cnt + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
//------------------------------------------------------------------
// i2c_bus_sync - SCL/SDA synchronizers and bus event detect. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_ff;
    logic [SYNC_STAGES-1:0] sda_ff;
    logic                   scl_d;
    logic                   scl_s;
    logic                   sda_s;

    assign scl_s = scl_ff[SYNC_STAGES-1];
    assign sda_s = sda_ff[SYNC_STAGES-1];

    // Idle bus is high, so flops reset to 1 to avoid a false START on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_ff    <= '1;
            sda_ff    <= '1;
            scl_d     <= 1'b1;
            sda       <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_ff    <= {scl_ff[SYNC_STAGES-2:0], scl_in};
            sda_ff    <= {sda_ff[SYNC_STAGES-2:0], sda_in};
            scl_d     <= scl_s;
            sda       <= sda_s;
            scl_rise  <= scl_s & ~scl_d;
            scl_fall  <= ~scl_s & scl_d;
            start_det <= scl_s & scl_d & sda & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda & sda_s;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
//------------------------------------------------------------------
// i2c_target - 7-bit addressed I2C responder engine. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TARGET_ADDR = 7'h50,
    parameter int                SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw_o
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            sda_oe   <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw_o     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            // tx_data is captured in the cycle tx_req is high.
            if (tx_req) begin
                shift <= tx_data;
            end
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= 4'd0;
                    end
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= 4'd0;
                                if (shift[6:0] == TARGET_ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    rw_o  <= sda;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IDLE;
                                end
                            end else begin
                                bit_cnt <= cnt_inc(bit_cnt);
                            end
                        end
                    end
                    // bit_cnt 0: waiting for the fall that starts the ACK;
                    // bit_cnt 1: waiting for the fall that ends it.
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                sda_oe  <= ~ACK;
                                bit_cnt <= 4'd1;
                                if (state == ST_ADDR_ACK && rw_o) begin
                                    tx_req <= 1'b1;
                                end
                            end else if (state == ST_ADDR_ACK && rw_o) begin
                                state   <= ST_RD_DATA;
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= 4'd1;
                            end else begin
                                state   <= ST_WR_DATA;
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (scl_rise) begin
                            shift <= {shift[6:0], sda};
                            if (bit_cnt == 4'd7) begin
                                rx_data  <= {shift[6:0], sda};
                                rx_valid <= 1'b1;
                                state    <= ST_WR_ACK;
                                bit_cnt  <= 4'd0;
                            end else begin
                                bit_cnt <= cnt_inc(bit_cnt);
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == BIT_CNT_MAX) begin
                                sda_oe  <= 1'b0;
                                state   <= ST_RD_ACK;
                                bit_cnt <= 4'd0;
                            end else begin
                                sda_oe  <= ~shift[7];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= cnt_inc(bit_cnt);
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda == NACK) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                tx_req <= 1'b1;
                                state  <= ST_RD_DATA;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
//------------------------------------------------------------------
// tb_i2c_target - directed bus-level bench for i2c_target. Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       msda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       rw_o;
    logic       sda_line;

    int         n_cmp = 0;
    int         n_err = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] rx_log [0:15];

    assign sda_line = msda & ~sda_oe;

    i2c_target dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .rw_o     (rw_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (tx_req) tx_cnt = tx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            msda = 1'b1;
            wait_clk(Q);
            scl = 1'b1;
            wait_clk(Q);
        end
        msda = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        msda = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        msda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        msda = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        msda = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        b = sda_line;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    // next_tx is presented before the master's ACK so it is ready for tx_req.
    task automatic read_byte(output logic [7:0] d, input logic ack_bit, input logic [7:0] next_tx);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        tx_data = next_tx;
        write_bit(ack_bit);
    endtask

    logic       ack;
    logic [7:0] rd;
    int         rx_base;

    initial begin
        wait_clk(4);
        chk("reset sda_oe", 32'(sda_oe), 32'h0);
        chk("reset rx_data", 32'(rx_data), 32'h00);
        chk("reset rx_valid", 32'(rx_valid), 32'h0);
        chk("reset tx_req", 32'(tx_req), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset rw_o", 32'(rw_o), 32'h0);
        rst_n = 1'b1;
        wait_clk(4);

        // Write 0xA5, 0x3C to 0x50.
        bus_start();
        write_byte(8'hA0, ack);
        chk("wr addr ack", 32'(ack), 32'h0);
        chk("wr busy", 32'(busy), 32'h1);
        chk("wr rw_o", 32'(rw_o), 32'h0);
        write_byte(8'hA5, ack);
        chk("wr byte0 ack", 32'(ack), 32'h0);
        write_byte(8'h3C, ack);
        chk("wr byte1 ack", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("wr rx count", 32'(rx_cnt), 32'd2);
        chk("wr rx byte0", 32'(rx_log[0]), 32'hA5);
        chk("wr rx byte1", 32'(rx_log[1]), 32'h3C);
        chk("wr busy after stop", 32'(busy), 32'h0);
        chk("wr state after stop", 32'(dut.state), 32'(ST_IDLE));

        // Wrong address 0x51 is ignored.
        bus_start();
        write_byte(8'hA2, ack);
        chk("bad addr nack", 32'(ack), 32'h1);
        write_byte(8'h55, ack);
        chk("bad addr data nack", 32'(ack), 32'h1);
        chk("bad addr busy", 32'(busy), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("bad addr rx count", 32'(rx_cnt), 32'd2);

        // Read two bytes from 0x50, ACK then NACK.
        tx_data = 8'h96;
        bus_start();
        write_byte(8'hA1, ack);
        chk("rd addr ack", 32'(ack), 32'h0);
        chk("rd rw_o", 32'(rw_o), 32'h1);
        chk("rd tx_req count 1", 32'(tx_cnt), 32'd1);
        read_byte(rd, ACK, 8'h0F);
        chk("rd byte0", 32'(rd), 32'h96);
        chk("rd tx_req count 2", 32'(tx_cnt), 32'd2);
        read_byte(rd, NACK, 8'hEE);
        chk("rd byte1", 32'(rd), 32'h0F);
        wait_clk(4);
        chk("rd tx_req after nack", 32'(tx_cnt), 32'd2);
        chk("rd sda_oe after nack", 32'(sda_oe), 32'h0);
        chk("rd state after nack", 32'(dut.state), 32'(ST_IDLE));
        chk("rd busy after nack", 32'(busy), 32'h0);
        bus_stop();
        wait_clk(6);

        // Write one byte, repeated START, read one byte.
        rx_base = rx_cnt;
        tx_data = 8'h77;
        bus_start();
        write_byte(8'hA0, ack);
        chk("rs wr addr ack", 32'(ack), 32'h0);
        chk("rs rw_o write", 32'(rw_o), 32'h0);
        write_byte(8'h5A, ack);
        chk("rs wr data ack", 32'(ack), 32'h0);
        bus_start();
        write_byte(8'hA1, ack);
        chk("rs rd addr ack", 32'(ack), 32'h0);
        chk("rs rw_o read", 32'(rw_o), 32'h1);
        read_byte(rd, NACK, 8'h00);
        chk("rs rd byte", 32'(rd), 32'h77);
        bus_stop();
        wait_clk(6);
        chk("rs rx count", 32'(rx_cnt - rx_base), 32'd1);
        chk("rs rx byte", 32'(rx_log[rx_base]), 32'h5A);

        // STOP after four data bits.
        rx_base = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        chk("mid stop addr ack", 32'(ack), 32'h0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        bus_stop();
        wait_clk(6);
        chk("mid stop state", 32'(dut.state), 32'(ST_IDLE));
        chk("mid stop sda_oe", 32'(sda_oe), 32'h0);
        chk("mid stop busy", 32'(busy), 32'h0);
        chk("mid stop rx count", 32'(rx_cnt - rx_base), 32'd0);

        // Reset while the address ACK is being driven.
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'hA0 >> i));
        chk("rst ack driven", 32'(sda_oe), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst async release", 32'(sda_oe), 32'h0);
        msda = 1'b1;
        scl  = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        rx_base = rx_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        chk("post rst addr ack", 32'(ack), 32'h0);
        write_byte(8'hC3, ack);
        chk("post rst data ack", 32'(ack), 32'h0);
        bus_stop();
        wait_clk(6);
        chk("post rst rx count", 32'(rx_cnt - rx_base), 32'd1);
        chk("post rst rx byte", 32'(rx_log[rx_base]), 32'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
